i2c_reg_sequencer: RTL and testbench
====================================

# i2c_reg_sequencer

Transaction sequencer in front of the I2C `master` byte engine. It accepts one register-level request at a time (write one byte to, or read one byte from, an 8-bit register of a 7-bit slave) and turns it into the ordered `master` command stream: start, address, register, data/restart, read, stop. It reports ACK/NACK and timeout status, so software and upper blocks never drive `cmd`, `wr_i2c` or `data_in` directly.

## Interface
- `DVSR`, 250: SCL divisor, driven constantly on `m_dvsr`.
- `TIMEOUT_CYCLES`, 65535: maximum `clk` cycles spent waiting on any single master command; width 16 bits.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer idle, request accepted when `req_valid && req_ready`.
- `req_rnw`  in  1  1 = register read, 0 = register write.
- `req_dev_addr`  in  7  slave address.
- `req_reg_addr`  in  8  register index.
- `req_wdata`  in  8  write data (ignored on read).
- `rsp_valid`  out  1  one-cycle pulse, transaction finished.
- `rsp_rdata`  out  8  read byte, valid with `rsp_valid`; 0 on write or error.
- `rsp_err`  out  2  00 ok, 01 NACK on address, 10 NACK on register/data byte, 11 timeout.
- `busy`  out  1  high from accept until `rsp_valid` cycle inclusive.
- `m_wr_i2c`  out  1  one-cycle command strobe to master.
- `m_cmd`  out  3  start 000, wr 001, rd 010, stop 011, restart 100.
- `m_data_in`  out  8  byte for wr; for rd bit0 = 1 (NACK, last byte).
- `m_dvsr`  out  16  = `DVSR`.
- `m_ready`, `m_done_tick`, `m_ack`, `m_data_out`  in  1,1,1,8  master status; `m_ack` = 0 means slave ACK.

## Operation
- States: IDLE, START, ADDR_W, REG, WDATA, RESTART, ADDR_R, READ, STOP, RESP. Each command state has ISSUE and WAIT phases.
- IDLE: `req_ready`=1. On accept, latch all `req_*` fields and go to START.
- ISSUE: wait for `m_ready`=1, then pulse `m_wr_i2c` for one cycle with `m_cmd`/`m_data_in`. Clear the timeout counter and enter WAIT.
- WAIT for start/restart/stop: ignore `m_ready` on the first WAIT cycle, then complete on `m_ready`=1.
- WAIT for wr/rd: complete on `m_done_tick`. On wr, sample `m_ack`. On rd, capture `m_data_out`.
- Write path: START → ADDR_W (`{dev,0}`) → REG → WDATA → STOP → RESP.
- Read path: START → ADDR_W → REG → RESTART → ADDR_R (`{dev,1}`) → READ → STOP → RESP.
- NACK on ADDR_W or ADDR_R: set err 01, skip to STOP. NACK on REG or WDATA: set err 10, skip to STOP.
- The first error is kept; later bytes are not sent.
- Timeout: counter increments every WAIT cycle and every ISSUE cycle with `m_ready`=0. Reaching `TIMEOUT_CYCLES` sets err 11 and goes straight to RESP; no stop is issued.
- RESP: `rsp_valid`=1 for one cycle, then IDLE.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=00, `m_wr_i2c`=0, `m_cmd`=011, `m_data_in`=0, `m_dvsr`=`DVSR`. State goes to IDLE.
- Reset mid-transaction: all outputs take reset values immediately. No response is generated, and the latched request is discarded.
- `req_ready` falls the cycle after accept and rises the cycle after `rsp_valid`. `req_valid` during RESP is not accepted.
- `m_wr_i2c` asserts at the earliest one cycle after entering ISSUE with `m_ready`=1. `m_cmd`/`m_data_in` hold stable from the strobe until the next ISSUE.
- Exactly one strobe per command. A write transaction produces 5 strobes; a read produces 7.
- `m_done_tick` or `m_ready` arriving while not in WAIT is ignored.
- `rsp_rdata`/`rsp_err` hold until the next accept.

## Test plan
- Write dev 0x55, reg 0x10, data 0xAA, all ACK → strobes 000, 001/0xAA, 001/0x10, 001/0xAA, 011 in order; `rsp_err`=00, `rsp_rdata`=0.
  - Correction to strobe 2: the address strobe is 001/0xAA (`{0x55,0}`) and the register strobe is 001/0x10.
- Read dev 0x55, reg 0x20, slave returns 0xF0 → strobes 000, 001/0xAA, 001/0x20, 100, 001/0xAB, 010/0x01, 011; `rsp_rdata`=0xF0, `rsp_err`=00.
- Address NACK (`m_ack`=1 on first byte) → next strobe is 011, no REG strobe; `rsp_err`=01.
- Data NACK on WDATA → 011 follows; `rsp_err`=10.
- `m_ready` held low after the start strobe with `TIMEOUT_CYCLES`=100 → `rsp_valid` at wait cycle 100, `rsp_err`=11, no stop strobe.
- `rst` low during READ WAIT → `busy`=0 and `req_ready`=1 with no `rsp_valid`. A new write accepted after release completes with err 00.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one register-level read/write request into the
// ordered command stream for the I2C master byte engine and reports
// ACK/NACK/timeout status back to the requester.
module i2c_reg_sequencer #(
    parameter int DVSR           = 250,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    // request / response
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rnw,
    input  logic [6:0]  req_dev_addr,
    input  logic [7:0]  req_reg_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        busy,
    // master byte engine
    output logic        m_wr_i2c,
    output logic [2:0]  m_cmd,
    output logic [7:0]  m_data_in,
    output logic [15:0] m_dvsr,
    input  logic        m_ready,
    input  logic        m_done_tick,
    input  logic        m_ack,
    input  logic [7:0]  m_data_out
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA,
        S_RESTART, S_ADDR_R, S_READ, S_STOP, S_RESP
    } state_t;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ADDR    = 2'b01;
    localparam logic [1:0] ERR_DATA    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic        wait_ph;     // 0 = ISSUE phase, 1 = WAIT phase
    logic        first_wait;  // first WAIT cycle: master has not seen the strobe yet
    logic [15:0] tcnt;

    logic        rnw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;

    logic [2:0]  iss_cmd;
    logic [7:0]  iss_data;
    logic        byte_cmd;
    state_t      nxt;
    logic        wait_done;
    logic [15:0] tcnt_inc;
    logic        timeout_hit;

    assign m_dvsr = 16'(DVSR);

    // Command, payload and successor state for the current command state
    always_comb begin
        iss_cmd  = CMD_STOP;
        iss_data = m_data_in;
        byte_cmd = 1'b0;
        nxt      = S_RESP;
        case (state)
            S_START:   begin iss_cmd = CMD_START; nxt = S_ADDR_W; end
            S_ADDR_W:  begin iss_cmd = CMD_WR; iss_data = {dev_q, 1'b0}; byte_cmd = 1'b1; nxt = S_REG; end
            S_REG:     begin iss_cmd = CMD_WR; iss_data = reg_q; byte_cmd = 1'b1;
                             nxt = rnw_q ? S_RESTART : S_WDATA; end
            S_WDATA:   begin iss_cmd = CMD_WR; iss_data = wdata_q; byte_cmd = 1'b1; nxt = S_STOP; end
            S_RESTART: begin iss_cmd = CMD_RESTART; nxt = S_ADDR_R; end
            S_ADDR_R:  begin iss_cmd = CMD_WR; iss_data = {dev_q, 1'b1}; byte_cmd = 1'b1; nxt = S_READ; end
            // rd byte with bit0 set: NACK it, single-byte read
            S_READ:    begin iss_cmd = CMD_RD; iss_data = 8'h01; byte_cmd = 1'b1; nxt = S_STOP; end
            S_STOP:    begin iss_cmd = CMD_STOP; nxt = S_RESP; end
            default:   ;
        endcase
    end

    // Byte commands finish on done_tick; bus conditions finish when the master
    // is ready again, skipping the cycle where ready still reflects pre-strobe idle.
    assign wait_done   = byte_cmd ? m_done_tick : (!first_wait && m_ready);
    assign tcnt_inc    = tcnt + 16'd1;
    assign timeout_hit = (tcnt_inc == TO_LIMIT);

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_ph    <= 1'b0;
            first_wait <= 1'b0;
            tcnt       <= '0;
            rnw_q      <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= ERR_OK;
            m_wr_i2c   <= 1'b0;
            m_cmd      <= CMD_STOP;
            m_data_in  <= '0;
        end else begin
            m_wr_i2c  <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        rnw_q     <= req_rnw;
                        dev_q     <= req_dev_addr;
                        reg_q     <= req_reg_addr;
                        wdata_q   <= req_wdata;
                        rsp_err   <= ERR_OK;
                        rsp_rdata <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        tcnt      <= '0;
                        wait_ph   <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    if (!wait_ph) begin
                        if (m_ready) begin
                            m_wr_i2c   <= 1'b1;
                            m_cmd      <= iss_cmd;
                            m_data_in  <= iss_data;
                            tcnt       <= '0;
                            wait_ph    <= 1'b1;
                            first_wait <= 1'b1;
                        end else if (timeout_hit) begin
                            // abandon the bus, no stop is attempted
                            if (rsp_err == ERR_OK) rsp_err <= ERR_TIMEOUT;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            tcnt <= tcnt_inc;
                        end
                    end else begin
                        first_wait <= 1'b0;
                        if (wait_done) begin
                            tcnt    <= '0;
                            wait_ph <= 1'b0;
                            if (byte_cmd && state != S_READ && m_ack) begin
                                rsp_err <= (state == S_ADDR_W || state == S_ADDR_R) ? ERR_ADDR : ERR_DATA;
                                state   <= S_STOP;
                            end else begin
                                if (state == S_READ) rsp_rdata <= m_data_out;
                                if (nxt == S_RESP) rsp_valid <= 1'b1;
                                state <= nxt;
                            end
                        end else if (timeout_hit) begin
                            if (rsp_err == ERR_OK) rsp_err <= ERR_TIMEOUT;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            tcnt <= tcnt_inc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Testbench for i2c_reg_sequencer: behavioural I2C master model, table of
// register transactions checked against an expected strobe scoreboard, plus
// hand-written timeout and mid-transaction reset sequences.
module tb_i2c_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rnw = 1'b0;
    logic [6:0]  req_dev_addr = '0;
    logic [7:0]  req_reg_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, busy, m_wr_i2c;
    logic [7:0]  rsp_rdata, m_data_in;
    logic [1:0]  rsp_err;
    logic [2:0]  m_cmd;
    logic [15:0] m_dvsr;
    logic        m_ready, m_done_tick, m_ack;
    logic [7:0]  m_data_out;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .m_wr_i2c(m_wr_i2c), .m_cmd(m_cmd), .m_data_in(m_data_in), .m_dvsr(m_dvsr),
        .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_data_out(m_data_out)
    );

    // ---------------- master model ----------------
    int          nack_pos = 0;    // strobe index in transaction to NACK (0 = none)
    logic [7:0]  slave_byte = '0;
    bit          hang = 1'b0;     // never return ready
    int          busy_cnt;
    int          scount;
    logic [2:0]  last_cmd;
    logic [10:0] got_q[$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Master: every strobe is logged; ready drops, returns 3 cycles later with done_tick for wr/rd
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready     <= 1'b1;
            m_done_tick <= 1'b0;
            m_ack       <= 1'b0;
            m_data_out  <= '0;
            busy_cnt    <= 0;
            scount      <= 0;
            last_cmd    <= 3'b011;
        end else begin
            m_done_tick <= 1'b0;
            if (m_wr_i2c) begin
                got_q.push_back({m_cmd, m_data_in});
                m_ready    <= 1'b0;
                busy_cnt   <= 3;
                last_cmd   <= m_cmd;
                scount     <= (m_cmd == 3'b000) ? 1 : scount + 1;
                m_ack      <= (m_cmd == 3'b010) ? 1'b1 :
                              (m_cmd == 3'b001 && nack_pos != 0 && scount == nack_pos);
                m_data_out <= slave_byte;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    if (last_cmd == 3'b001 || last_cmd == 3'b010) m_done_tick <= 1'b1;
                    if (!hang) m_ready <= 1'b1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit         rnw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic [7:0] rb;
        int         npos;
        logic [1:0] err;
        logic [7:0] rdata;
    } vec_t;

    logic [10:0] exp_q[$];

    // data bits only matter for wr/rd strobes
    function automatic logic [10:0] skey(input logic [10:0] s);
        return (s[10:8] == 3'b001 || s[10:8] == 3'b010) ? s : {s[10:8], 8'h00};
    endfunction

    // expected strobe list: full command sequence, cut after the NACKed byte, then stop
    task automatic push_exp(input vec_t v);
        logic [10:0] full[$];
        full = {};
        full.push_back({3'b000, 8'h00});
        full.push_back({3'b001, v.dev, 1'b0});
        full.push_back({3'b001, v.rg});
        if (!v.rnw) begin
            full.push_back({3'b001, v.wd});
        end else begin
            full.push_back({3'b100, 8'h00});
            full.push_back({3'b001, v.dev, 1'b1});
            full.push_back({3'b010, 8'h01});
        end
        exp_q.delete();
        for (int i = 0; i < full.size(); i++) begin
            exp_q.push_back(full[i]);
            if (v.npos != 0 && i == v.npos) break;
        end
        exp_q.push_back({3'b011, 8'h00});
    endtask

    task automatic cmp_strobes(input string tag);
        int n;
        chk({tag, " nstrobe"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s strobe%0d", tag, i), skey(got_q[i]), skey(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        nack_pos   = v.npos;
        slave_byte = v.rb;
        push_exp(v);
        @(negedge clk);
        req_valid    = 1'b1;
        req_rnw      = v.rnw;
        req_dev_addr = v.dev;
        req_reg_addr = v.rg;
        req_wdata    = v.wd;
        @(negedge clk);
        req_valid    = 1'b0;
        // scramble inputs: the request must already be latched
        req_rnw      = ~v.rnw;
        req_dev_addr = ~v.dev;
        req_reg_addr = ~v.rg;
        req_wdata    = ~v.wd;
        chk({tag, " ready_low"}, req_ready, 1'b0);
        chk({tag, " busy_high"}, busy, 1'b1);
        n = 0;
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        chk({tag, " rsp_seen"}, (n < 500), 1'b1);
        chk({tag, " err"}, rsp_err, v.err);
        chk({tag, " rdata"}, rsp_rdata, v.rdata);
        chk({tag, " busy_at_rsp"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, " rsp_pulse"}, rsp_valid, 1'b0);
        chk({tag, " ready_back"}, req_ready, 1'b1);
        chk({tag, " err_hold"}, rsp_err, v.err);
        cmp_strobes(tag);
    endtask

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t0, hits;
        vecs[0] = '{0, 7'h55, 8'h10, 8'hAA, 8'h00, 0, 2'b00, 8'h00};
        vecs[1] = '{1, 7'h55, 8'h20, 8'h00, 8'hF0, 0, 2'b00, 8'hF0};
        vecs[2] = '{0, 7'h55, 8'h10, 8'hAA, 8'h00, 1, 2'b01, 8'h00};
        vecs[3] = '{0, 7'h55, 8'h10, 8'hAA, 8'h00, 3, 2'b10, 8'h00};
        vecs[4] = '{1, 7'h55, 8'h20, 8'h00, 8'hF0, 2, 2'b10, 8'h00};
        vecs[5] = '{1, 7'h55, 8'h20, 8'h00, 8'hF0, 4, 2'b01, 8'h00};
        vecs[6] = '{0, 7'h7F, 8'hFF, 8'h00, 8'h00, 0, 2'b00, 8'h00};
        vecs[7] = '{1, 7'h00, 8'h00, 8'h00, 8'hFF, 0, 2'b00, 8'hFF};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst req_ready", req_ready, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst rsp_valid", rsp_valid, 1'b0);
        chk("rst rsp_rdata", rsp_rdata, 8'h00);
        chk("rst rsp_err", rsp_err, 2'b00);
        chk("rst m_wr_i2c", m_wr_i2c, 1'b0);
        chk("rst m_cmd", m_cmd, 3'b011);
        chk("rst m_data_in", m_data_in, 8'h00);
        chk("rst m_dvsr", m_dvsr, 16'd250);
        rst = 1'b1;
        @(negedge clk);
        chk("idle req_ready", req_ready, 1'b1);
        got_q.delete();

        for (int k = 0; k < 8; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // timeout: master never becomes ready after the start strobe
        hang = 1'b1;
        nack_pos = 0;
        @(negedge clk);
        req_valid = 1'b1; req_rnw = 1'b0; req_dev_addr = 7'h55; req_reg_addr = 8'h10; req_wdata = 8'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!m_wr_i2c && n < 50) begin @(negedge clk); n++; end
        chk("to start_strobe", (n < 50), 1'b1);
        t0 = cyc;
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk("to rsp_seen", (n < 300), 1'b1);
        chk("to latency", cyc - t0, 100);
        chk("to err", rsp_err, 2'b11);
        chk("to rdata", rsp_rdata, 8'h00);
        repeat (20) @(negedge clk);
        chk("to nstrobe", got_q.size(), 1);
        if (got_q.size() > 0) chk("to strobe0", got_q[0][10:8], 3'b000);
        got_q.delete();
        hang = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset during READ wait
        slave_byte = 8'h3C;
        @(negedge clk);
        req_valid = 1'b1; req_rnw = 1'b1; req_dev_addr = 7'h55; req_reg_addr = 8'h20;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(m_wr_i2c && m_cmd == 3'b010) && n < 200) begin @(negedge clk); n++; end
        chk("mid read_strobe", (n < 200), 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid busy", busy, 1'b0);
        chk("mid req_ready", req_ready, 1'b1);
        chk("mid m_cmd", m_cmd, 3'b011);
        chk("mid m_wr_i2c", m_wr_i2c, 1'b0);
        hits = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid) hits++; end
        rst = 1'b1;
        repeat (10) begin @(negedge clk); if (rsp_valid) hits++; end
        chk("mid no_rsp", hits, 0);
        got_q.delete();
        run_vec(vecs[0], "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
